// File: rtl/td4_pkg.sv
// Shared TD4 definitions: program-loader states, program depth and the
// op/im field positions used by both the loader and the core's decoder.
package td4_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    RUN   = 2'd3
  } ld_state_e;

  localparam int PROG_DEPTH = 16;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 4;
  localparam int IM_MSB = 3;
  localparam int IM_LSB = 0;

endpackage

// File: rtl/prog_ram.sv
// TD4 instruction store: synchronous write, asynchronous read so the core
// can fetch combinationally from pc.
module prog_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader.sv
// TD4 program loader: streams a program image into prog_ram and holds the
// core in reset until a full image is in place. Define CHECKSUM_EN to require
// a trailing two's-complement checksum byte that is verified before RUN.
module prog_loader
  import td4_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [3:0]        op,
  output logic [3:0]        im,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef CHECKSUM_EN
  // Checksum byte rides at index DEPTH and is never stored.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH);
`else
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
`endif

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hs;
  logic              we;
  logic [DATA_W-1:0] rdata;

  assign s_ready = (state_q == LOAD);
  assign hs      = s_valid & s_ready;
  // Gate by rst so a reset cycle never lands a byte; addr MSB marks the checksum slot.
  assign we      = hs & ~rst & ~addr_q[ADDR_W];

`ifdef CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       sum_ok;

  assign sum_ok = (sum_q == 8'd0);

  always_comb begin
    sum_d = sum_q;
    if (state_q != LOAD)  sum_d = 8'd0;
    else if (hs)          sum_d = sum_q + s_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= 8'd0;
    else     sum_q <= sum_d;
  end
`else
  logic sum_ok;
  assign sum_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    unique case (state_q)
      WAIT: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (hs) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == LAST_IDX) begin
`ifdef CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = RUN;
`endif
          end
        end
      end
      CHECK: begin
        if (sum_ok) begin
          state_d = RUN;
        end else begin
          state_d = WAIT;
          err_d   = 1'b1;
        end
      end
      RUN: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
        end
      end
      default: state_d = WAIT;
    endcase
    // Registered from the next state so the core stops on the same edge LOAD begins.
    cpu_rst_d = (state_d != RUN);
    done_d    = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT;
      addr_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  prog_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (addr_q[ADDR_W-1:0]),
    .wdata (s_data),
    .raddr (pc),
    .rdata (rdata)
  );

  assign op      = rdata[OP_MSB:OP_LSB];
  assign im      = rdata[IM_MSB:IM_LSB];
  assign cpu_rst = cpu_rst_q;
  assign done    = done_q;
`ifdef CHECKSUM_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load, throttled load, reload, reset and
// start corner cases; checksum pass/fail when CHECKSUM_EN is defined.
module tb_prog_loader;

  typedef logic [7:0] img_t [17];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic [3:0] pc = 4'h0;
  logic       s_ready;
  logic [3:0] op, im;
  logic       cpu_rst, done, err;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  bit ready_drop = 1'b0;

  img_t timer = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                  8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF, 8'hF7};
  img_t zeros;
  img_t newimg;
  img_t img4;

  prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .pc      (pc),
    .op      (op),
    .im      (im),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (s_valid && s_ready) hs_cnt++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives bytes img[first..first+n-1]; s_valid follows pat bit per cycle.
  task automatic send_bytes(input img_t img, input int first, input int n,
                            input logic [31:0] pat);
    int i = first;
    int cyc = 0;
    bit hs;
    ready_drop = 1'b0;
    while (i < first + n && cyc < 400) begin
      s_valid = pat[cyc % 32];
      s_data  = img[i];
      @(negedge clk);
      hs = s_valid && s_ready;
      if (!s_ready) ready_drop = 1'b1;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    s_valid = 1'b0;
    if (i < first + n) begin
      checks++; failures++;
      $display("FAIL send_timeout sent=%0d wanted=%0d", i - first, n);
    end
  endtask

  task automatic test_reset();
    tick();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL rst_cpu_rst got=%b exp=1", cpu_rst); end
    checks++; if (done !== 1'b0)    begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0)     begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    rst = 1'b0;
    tick(); tick();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL wait_idle_s_ready got=%b exp=0", s_ready); end
  endtask

  task automatic test_load();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL load_s_ready got=%b exp=1", s_ready); end
    send_bytes(timer, 0, 15, 32'hFFFF_FFFF);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL load_done_early got=%b exp=0", done); end
    send_bytes(timer, 15, 1, 32'hFFFF_FFFF);
    checks++; if (done !== 1'b1)    begin failures++; $display("FAIL load_done got=%b exp=1", done); end
    checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL load_cpu_rst got=%b exp=0", cpu_rst); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL run_s_ready got=%b exp=0", s_ready); end
    pc = 4'd2; #1;
    checks++; if ({op, im} !== 8'hE1) begin failures++; $display("FAIL load_pc2 got=%h exp=e1", {op, im}); end
    pc = 4'd15; #1;
    checks++; if ({op, im} !== 8'hFF) begin failures++; $display("FAIL load_pc15 got=%h exp=ff", {op, im}); end
  endtask

  task automatic test_reload_zero();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reload_cpu_rst got=%b exp=1", cpu_rst); end
    checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reload_done got=%b exp=0", done); end
    pc = 4'd0; #1;
    checks++; if ({op, im} !== 8'hB7) begin failures++; $display("FAIL reload_no_early_write got=%h exp=b7", {op, im}); end
    send_bytes(zeros, 0, 16, 32'hFFFF_FFFF);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL reload_done_after got=%b exp=1", done); end
    for (int a = 0; a < 16; a++) begin
      pc = a[3:0]; #1;
      checks++;
      if ({op, im} !== 8'h00) begin failures++; $display("FAIL reload_ram[%0d] got=%h exp=00", a, {op, im}); end
    end
  endtask

  task automatic test_throttled();
    start = 1'b1; tick(); start = 1'b0;
    hs_cnt = 0;
    send_bytes(timer, 0, 16, 32'h6C93_5A1D);
    checks++; if (ready_drop !== 1'b0) begin failures++; $display("FAIL thr_ready_held got=%b exp=0", ready_drop); end
    s_valid = 1'b1; s_data = 8'h55;
    tick(); tick(); tick();
    s_valid = 1'b0;
    checks++; if (hs_cnt !== 16) begin failures++; $display("FAIL thr_write_count got=%0d exp=16", hs_cnt); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL thr_done got=%b exp=1", done); end
    for (int a = 0; a < 16; a++) begin
      pc = a[3:0]; #1;
      checks++;
      if ({op, im} !== timer[a]) begin failures++; $display("FAIL thr_ram[%0d] got=%h exp=%h", a, {op, im}, timer[a]); end
    end
  endtask

  task automatic test_rst_midload();
    start = 1'b1; tick(); start = 1'b0;
    send_bytes(newimg, 0, 7, 32'hFFFF_FFFF);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (done !== 1'b0)    begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL midrst_cpu_rst got=%b exp=1", cpu_rst); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL midrst_s_ready got=%b exp=0", s_ready); end
    for (int a = 0; a < 16; a++) begin
      pc = a[3:0]; #1;
      checks++;
      if (a < 7) begin
        if ({op, im} !== newimg[a]) begin failures++; $display("FAIL midrst_ram[%0d] got=%h exp=%h", a, {op, im}, newimg[a]); end
      end else begin
        if ({op, im} !== timer[a]) begin failures++; $display("FAIL midrst_ram[%0d] got=%h exp=%h", a, {op, im}, timer[a]); end
      end
    end
  endtask

  task automatic test_start_corner();
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    tick();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_start_wait got=%b exp=0", s_ready); end
    start = 1'b1; tick(); start = 1'b0;
    send_bytes(img4, 0, 3, 32'hFFFF_FFFF);
    start = 1'b1; tick(); start = 1'b0;
    send_bytes(img4, 3, 12, 32'hFFFF_FFFF);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midstart_early got=%b exp=0", done); end
    send_bytes(img4, 15, 1, 32'hFFFF_FFFF);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL midstart_done got=%b exp=1", done); end
    for (int a = 0; a < 16; a++) begin
      pc = a[3:0]; #1;
      checks++;
      if ({op, im} !== img4[a]) begin failures++; $display("FAIL midstart_ram[%0d] got=%h exp=%h", a, {op, im}, img4[a]); end
    end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    img_t bad;
    bad = timer;
    bad[16] = 8'hF8;
    start = 1'b1; tick(); start = 1'b0;
    send_bytes(timer, 0, 17, 32'hFFFF_FFFF);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL ck_check_state got=%b exp=0", done); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ck_pass_done got=%b exp=1", done); end
    checks++; if (err !== 1'b0)  begin failures++; $display("FAIL ck_pass_err got=%b exp=0", err); end
    start = 1'b1; tick(); start = 1'b0;
    send_bytes(bad, 0, 17, 32'hFFFF_FFFF);
    tick();
    checks++; if (err !== 1'b1)     begin failures++; $display("FAIL ck_fail_err got=%b exp=1", err); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL ck_fail_cpu_rst got=%b exp=1", cpu_rst); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL ck_fail_wait got=%b exp=0", s_ready); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (err !== 1'b0)     begin failures++; $display("FAIL ck_err_clear got=%b exp=0", err); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL ck_reload got=%b exp=1", s_ready); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 17; i++) begin
      zeros[i]  = 8'h00;
      newimg[i] = 8'h80 | 8'(i);
      img4[i]   = 8'h40 + 8'(i);
    end
    test_reset();
`ifdef CHECKSUM_EN
    test_checksum();
`else
    test_load();
    test_reload_zero();
    test_throttled();
    test_rst_midload();
    test_start_corner();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name:
prog_loader

Overview:
- Writer side of the TD4 program store: accepts a 16-byte program over a valid/ready byte stream.
- Writes the bytes into a 16x8 instruction RAM and serves the CPU's combinational fetch port ({op, im} indexed by pc).
- Holds the CPU in reset while loading and releases it once a complete image is in place.
- Sits between the board-level byte source (switch/serial front end) and the TD4 core, in place of the fixed ROM.

Parameters:
- ADDR_W, 4, program address width; depth = 2**ADDR_W.
- DATA_W, 8, instruction width; split into op = upper 4 bits, im = lower 4 bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request to begin a (re)load.
- s_valid  input  1  byte source has data.
- s_data  input  DATA_W  program byte, address order 0..15.
- s_ready  output  1  loader accepts a byte this cycle.
- pc  input  ADDR_W  CPU fetch address.
- op  output  4  s_data[7:4] of ram[pc]; combinational read.
- im  output  4  s_data[3:0] of ram[pc]; combinational read.
- cpu_rst  output  1  registered hold-in-reset to the TD4 core.
- done  output  1  registered; valid image loaded, CPU running.
- err  output  1  registered checksum failure flag (CHECKSUM_EN only; tied 0 otherwise).

Behaviour:
- Reset values: state = WAIT, addr = 0, s_ready = 0, cpu_rst = 1, done = 0, err = 0.
- RAM is not cleared by reset.
- States:
  - WAIT: idle after reset; cpu_rst = 1.
  - LOAD: s_ready = 1; each cycle with s_valid & s_ready writes ram[addr] <= s_data and increments addr.
  - CHECK: CHECKSUM_EN only.
  - RUN: cpu_rst = 0, done = 1.
- Transitions:
  - WAIT --start--> LOAD, addr = 0.
  - LOAD, handshake at addr = 15 --> RUN, or CHECK when CHECKSUM_EN.
  - RUN --start--> LOAD. On the next edge cpu_rst = 1 and done = 0, so the CPU is stopped before any write lands.
- Latency: the write appears on op/im one cycle after the handshake edge. No bypass.
- addr is a 5-bit counter internally; no wrap occurs, because LOAD exits on the 16th byte.
- start during LOAD or CHECK: ignored; no restart.
- s_valid outside LOAD: ignored; s_ready = 0.
- rst and start in the same cycle: rst wins.
- rst mid-load: back to WAIT. The partial image stays in RAM, but done = 0 and cpu_rst = 1 until a full reload.
- pc is read in every state; op/im are undefined before the first write to that address.

Optional Feature:
- CHECKSUM_EN defined:
  - LOAD accepts a 17th byte, which is checksum only and not stored.
  - CHECK tests (sum of the 17 bytes) mod 256 == 0.
  - Pass: RUN, err = 0.
  - Fail: WAIT, err = 1, cpu_rst = 1. err is cleared by the next start or by rst.
- CHECKSUM_EN undefined:
  - 16 bytes, no CHECK state, err = 0.
  - Checksum accumulator is not instantiated.

Decomposition:
- Package td4_pkg:
  - State enum (WAIT, LOAD, CHECK, RUN).
  - PROG_DEPTH = 16.
  - OP/IM field slice constants.
  - Shared with the core's decoder.
- One sub-module, prog_ram:
  - 16xDATA_W array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr -> rdata).
  - The controller FSM stays in prog_loader.

Test Plan:
- Load the 3-minute-timer image (0xB7, 0x01, 0xE1, 0x01, 0xE3, 0xB6, 0x01, 0xE6, 0x01, 0xE8, 0xB0, 0xB4, 0x01, 0xEA, 0xB8, 0xFF) with s_valid held high -> done = 1 and cpu_rst = 0 one cycle after the 16th handshake; pc = 2 gives op = 0xE, im = 0x1; pc = 15 gives op = 0xF, im = 0xF.
- Same image with s_valid toggling randomly (about 50%) -> identical RAM contents; exactly 16 writes; s_ready stays 1 throughout LOAD.
- In RUN, pulse start and send 16 bytes of 0x00 -> cpu_rst = 1 on the edge after start and before any write; all op/im = 0 after reload.
- rst after 7 bytes -> state WAIT, done = 0, cpu_rst = 1; ram[0..6] hold the new data, ram[7..15] hold the old data.
- start asserted together with rst -> stays in WAIT; start during LOAD -> addr unchanged.
- CHECKSUM_EN: 16 bytes plus correct two's-complement byte -> RUN, err = 0. Wrong byte (+1) -> WAIT, err = 1, cpu_rst = 1. Next start clears err.
